decoder_scan: RTL and testbench
===============================

Name: decoder_scan

Overview:
- Parametrised, clocked successor to the team's 3-to-8 active-low decoder. Gating keeps the G1 / G2A_N / G2B_N scheme.
- Two modes:
  - Direct: registered decode of an external select.
  - Scan: an internal sequencer walks the outputs, holding each one for a programmable dwell time.
- Sits between control logic and strobed loads such as display digits, chip selects or mux rows.

Parameters:
- SEL_W, 3: select width. Output count NOUT = 2**SEL_W is a localparam.
- DWELL_W, 8: width of the dwell counter.
- DWELL, 4: cycles each output stays asserted in scan mode. Legal range 1 .. 2**DWELL_W-1.
- SCAN_LAST, 2**SEL_W-1: highest index visited in scan mode. Scan wraps to 0 after it. Must be < NOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- g1  in  1  active-high enable.
- g2a_n  in  1  active-low enable.
- g2b_n  in  1  active-low enable.
- mode  in  1  0 = direct, 1 = scan.
- sel  in  SEL_W  select used in direct mode.
- scan_start  in  1  pulse: start or restart a scan at index 0.
- scan_stop  in  1  pulse: stop the scan.
- y_n  out  NOUT  decoded outputs, active-low, registered.
- cur_sel  out  SEL_W  index currently driven (or last driven).
- wrap  out  1  one-cycle pulse when the scan wraps SCAN_LAST -> 0.
- busy  out  1  high while in SCAN (and BLANK, if compiled in).

Behaviour:
- Reset (async assert, sync release):
  - y_n = all ones, cur_sel = 0, wrap = 0, busy = 0.
  - Dwell counter = 0, state = IDLE.
  - Asserting reset mid-scan aborts immediately.
- en = g1 & ~g2a_n & ~g2b_n, sampled every edge.
  - en = 0: y_n = all ones on the next edge. Dwell counter and cur_sel freeze. State is kept.
  - en returning to 1: resumes where it stopped.
- States: IDLE, DIRECT, SCAN, BLANK (BLANK only with the macro).
- IDLE:
  - y_n all ones.
  - mode = 0 -> DIRECT.
  - mode = 1 and scan_start -> SCAN, cur_sel = 0, dwell = 0, busy = 1.
- DIRECT:
  - Each enabled edge: cur_sel <= sel, y_n <= ~(1 << sel). One-cycle latency.
  - mode = 1 -> IDLE.
- SCAN:
  - y_n = ~(1 << cur_sel).
  - Each enabled edge, dwell increments. At dwell == DWELL-1: dwell <= 0 and cur_sel advances.
  - Advance rule: cur_sel == SCAN_LAST -> 0, and wrap pulses on that same edge. Otherwise cur_sel + 1.
  - DWELL = 1 advances every cycle.
- Precedence in SCAN, highest first: scan_stop (-> IDLE, y_n all ones, busy 0), then mode = 0 (-> DIRECT), then scan_start (restart at index 0, dwell 0, no wrap pulse), then normal advance.
- Simultaneous scan_start and scan_stop: stop wins.
- Exactly one y_n bit is low whenever outputs are active. Never more than one.
- wrap is 0 in every other case. It is not asserted while en = 0.

Optional Feature:
- Macro: DECODER_BLANK_EN.
- Defined:
  - Every scan advance passes through BLANK for exactly one cycle: y_n all ones, cur_sel already updated, dwell held at 0. Then returns to SCAN.
  - In DIRECT, a change of sel gives one all-ones cycle before the new output goes low. Latency for a changed sel is 2; an unchanged sel keeps latency 1.
  - scan_stop or mode = 0 during BLANK behave as in SCAN.
  - busy stays 1 during BLANK.
- Undefined: BLANK state and the blank logic are absent; outputs switch directly (make-before-break-free single-edge transition).

Decomposition:
- Package decoder_pkg:
  - State enum (IDLE, DIRECT, SCAN, BLANK).
  - Mode constants MODE_DIRECT = 0, MODE_SCAN = 1.
  - Function onehot_n(sel) returning the active-low one-hot vector.
- One sub-module, decoder_dwell_ctr: DWELL_W counter with enable, clear and terminal-count output, reused by the scan sequencer.

Test Plan:
- Reset, then mode = 0, g1 = 1, g2a_n = g2b_n = 0, sel = 5 -> next edge y_n = 8'b1101_1111, cur_sel = 5.
- Direct, sel = 2 with g2a_n = 1 -> y_n = 8'hFF; release g2a_n -> next edge y_n = 8'b1111_1011.
- Scan with DWELL = 4, SCAN_LAST = 7, scan_start -> cur_sel 0..7 each held 4 cycles. wrap pulses once at the 7 -> 0 edge (cycle 32 after start). busy = 1 throughout.
- Scan with DWELL = 1, SCAN_LAST = 2 -> cur_sel 0, 1, 2, 0, … every cycle, wrap every third cycle. Drop g1 for 3 cycles -> y_n = FF and cur_sel frozen, then resumes.
- Scan with scan_start and scan_stop together at cur_sel = 3 -> IDLE, y_n = FF, busy = 0. Assert rst_n = 0 mid-scan -> outputs reset immediately, without waiting for a clock edge.
- With DECODER_BLANK_EN, DWELL = 2 -> sequence Y0, Y0, FF, Y1, Y1, FF, …. Direct sel 1 -> 4 shows one FF cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_scan shared types: FSM state, mode encodings and the
// active-low one-hot helper used by the scan/direct decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper supports; callers narrow the result.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_NOUT  = 2**MAX_SEL_W;

  function automatic logic [MAX_NOUT-1:0] onehot_n(
    input logic [MAX_SEL_W-1:0] sel
  );
    logic [MAX_NOUT-1:0] v;
    v      = '1;
    v[sel] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/decoder_dwell_ctr.sv
// Dwell counter for the scan sequencer: counts 0..LAST then wraps.
// Ports: clk, rst_n, en_i (count), clr_i (to 0, wins), tc_o (cnt==LAST).
module decoder_dwell_ctr #(
  parameter int           W    = 8,
  parameter logic [W-1:0] LAST = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Clocked 2**SEL_W-output active-low decoder with direct and scan modes.
// Ports: clk, rst_n, g1/g2a_n/g2b_n (enables), mode, sel, scan_start,
// scan_stop -> y_n, cur_sel, wrap, busy. Macro DECODER_BLANK_EN adds
// a one-cycle all-ones gap on every output change (BLANK state).
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DWELL_W   = 8,
  parameter int DWELL     = 4,
  parameter int SCAN_LAST = 2**SEL_W-1,
  localparam int NOUT     = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g1,
  input  logic             g2a_n,
  input  logic             g2b_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan_start,
  input  logic             scan_stop,
  output logic [NOUT-1:0]  y_n,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [NOUT-1:0]  y_q, y_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic             wrap_q, wrap_d;

  logic             en;
  logic             run;
  logic             tc;
  logic             adv;
  logic             at_last;
  logic [SEL_W-1:0] nxt;

  function automatic logic [NOUT-1:0] dec_n(
    input logic [SEL_W-1:0] s
  );
    return NOUT'(onehot_n(MAX_SEL_W'(s)));
  endfunction

  assign en = g1 & ~g2a_n & ~g2b_n;

  // Undisturbed scan step: no stop, no mode change, no restart.
  assign run = en & (state_q == ST_SCAN)
             & ~scan_stop & ~scan_start
             & (mode == MODE_SCAN);

  assign adv     = run & tc;
  assign at_last = (cur_q == SEL_W'(SCAN_LAST));
  assign nxt     = at_last ? '0 : cur_q + SEL_W'(1);

  // Cleared whenever enabled outside a plain scan step, so every
  // (re)entry into SCAN and every BLANK cycle sees dwell 0.
  decoder_dwell_ctr #(
    .W    (DWELL_W),
    .LAST (DWELL_W'(DWELL-1))
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (run),
    .clr_i (en & ~run),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
          end else if (scan_start & ~scan_stop) begin
            state_d = ST_SCAN;
          end
        end
        ST_DIRECT: begin
          if (mode == MODE_SCAN) begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN, ST_BLANK: begin
          if (scan_stop) begin
            state_d = ST_IDLE;
          end else if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
          end else begin
            state_d = ST_SCAN;
`ifdef DECODER_BLANK_EN
            if (adv) begin
              state_d = ST_BLANK;
            end
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    y_d    = '1;
    cur_d  = cur_q;
    wrap_d = 1'b0;
    if (en) begin
      unique case (state_d)
        ST_IDLE: begin
          y_d = '1;
        end
        ST_DIRECT: begin
          cur_d = sel;
          y_d   = dec_n(sel);
`ifdef DECODER_BLANK_EN
          if (sel != cur_q) begin
            y_d = '1;
          end
`endif
        end
        ST_SCAN, ST_BLANK: begin
          if (adv) begin
            cur_d  = nxt;
            wrap_d = at_last;
          end else if (scan_start) begin
            cur_d = '0;
          end
          if (state_d == ST_SCAN) begin
            y_d = dec_n(cur_d);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '1;
      cur_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      cur_q  <= cur_d;
      wrap_q <= wrap_d;
    end
  end

  assign y_n     = y_q;
  assign cur_sel = cur_q;
  assign wrap    = wrap_q;
  assign busy    = (state_q == ST_SCAN) | (state_q == ST_BLANK);

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: three instances with different
// dwell/scan-last settings, a cycle model and directed literal checks.
module tb_decoder_scan;

`ifdef DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam int PDW   [3] = '{4, 1, 2};
  localparam int PLAST [3] = '{7, 2, 7};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       g1, g2a_n, g2b_n;
  logic       mode;
  logic [2:0] sel;
  logic       scan_start, scan_stop;

  logic [7:0] y0, y1, y2;
  logic [2:0] c0, c1, c2;
  logic       w0, w1, w2;
  logic       b0, b1, b2;

  logic [7:0] ya [3];
  logic [2:0] ca [3];
  logic       wa [3];
  logic       ba [3];

  assign ya[0] = y0;
  assign ya[1] = y1;
  assign ya[2] = y2;
  assign ca[0] = c0;
  assign ca[1] = c1;
  assign ca[2] = c2;
  assign wa[0] = w0;
  assign wa[1] = w1;
  assign wa[2] = w2;
  assign ba[0] = b0;
  assign ba[1] = b1;
  assign ba[2] = b2;

  decoder_scan #(
    .SEL_W(3), .DWELL_W(8), .DWELL(4), .SCAN_LAST(7)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n),
    .g2b_n(g2b_n), .mode(mode), .sel(sel),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .y_n(y0), .cur_sel(c0), .wrap(w0), .busy(b0)
  );

  decoder_scan #(
    .SEL_W(3), .DWELL_W(8), .DWELL(1), .SCAN_LAST(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n),
    .g2b_n(g2b_n), .mode(mode), .sel(sel),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .y_n(y1), .cur_sel(c1), .wrap(w1), .busy(b1)
  );

  decoder_scan #(
    .SEL_W(3), .DWELL_W(8), .DWELL(2), .SCAN_LAST(7)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n),
    .g2b_n(g2b_n), .mode(mode), .sel(sel),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .y_n(y2), .cur_sel(c2), .wrap(w2), .busy(b2)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: state 0 idle, 1 direct, 2 scan, 3 blank; y = -1 all ones.
  int m_st  [3];
  int m_cur [3];
  int m_dw  [3];
  int m_y   [3];
  bit m_wr  [3];

  function automatic logic [7:0] ey(input int y);
    if (y < 0) return 8'hFF;
    return ~(8'd1 << y);
  endfunction

  task automatic mdl_direct(input int k);
    if (BLANK && int'(sel) != m_cur[k]) m_y[k] = -1;
    else m_y[k] = int'(sel);
    m_cur[k] = int'(sel);
  endtask

  task automatic mdl_step(input int k);
    bit e;
    e = g1 && !g2a_n && !g2b_n;
    m_wr[k] = 1'b0;
    if (!e) begin
      m_y[k] = -1;
    end else if (m_st[k] == 0) begin
      if (mode == 1'b0) begin
        m_st[k] = 1;
        mdl_direct(k);
      end else if (scan_start && !scan_stop) begin
        m_st[k] = 2; m_cur[k] = 0; m_dw[k] = 0; m_y[k] = 0;
      end else begin
        m_y[k] = -1;
      end
    end else if (m_st[k] == 1) begin
      if (mode == 1'b1) begin
        m_st[k] = 0; m_y[k] = -1;
      end else begin
        mdl_direct(k);
      end
    end else begin
      if (scan_stop) begin
        m_st[k] = 0; m_y[k] = -1;
      end else if (mode == 1'b0) begin
        m_st[k] = 1;
        mdl_direct(k);
      end else if (scan_start) begin
        m_st[k] = 2; m_cur[k] = 0; m_dw[k] = 0; m_y[k] = 0;
      end else if (m_st[k] == 3) begin
        m_st[k] = 2; m_y[k] = m_cur[k];
      end else if (m_dw[k] == PDW[k] - 1) begin
        m_dw[k] = 0;
        m_wr[k] = (m_cur[k] == PLAST[k]);
        m_cur[k] = m_wr[k] ? 0 : m_cur[k] + 1;
        if (BLANK) begin
          m_st[k] = 3; m_y[k] = -1;
        end else begin
          m_y[k] = m_cur[k];
        end
      end else begin
        m_dw[k]++;
        m_y[k] = m_cur[k];
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_st[k] = 0; m_cur[k] = 0; m_dw[k] = 0;
        m_y[k] = -1; m_wr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) mdl_step(k);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.y_n", k), 32'(ya[k]), 32'(ey(m_y[k])));
        chk($sformatf("u%0d.cur_sel", k), 32'(ca[k]), m_cur[k]);
        chk($sformatf("u%0d.wrap", k), 32'(wa[k]), 32'(m_wr[k]));
        chk($sformatf("u%0d.busy", k), 32'(ba[k]),
            32'(m_st[k] >= 2));
        chk($sformatf("u%0d.onehot", k),
            32'($countones(~ya[k]) <= 1), 32'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, limit 200000");
    $fatal(1);
  end

  logic [7:0] seq [6];
  logic [7:0] seq_nb [6] = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB};
  logic [7:0] seq_bl [6] = '{8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFF};
  int fw0, nw0, nw1;

  initial begin
    rst_n = 1'b1;
    g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
    mode = 1'b0; sel = 3'd5;
    scan_start = 1'b0; scan_stop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst.y_n", 32'(y0), 32'hFF);
    chk("rst.cur_sel", 32'(c0), 32'd0);
    chk("rst.wrap", 32'(w0), 32'd0);
    chk("rst.busy", 32'(b0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct sel 5
    step(1);
    chk("dir5.first", 32'(y0), BLANK ? 32'hFF : 32'hDF);
    step(1);
    chk("dir5.y_n", 32'(y0), 32'hDF);
    chk("dir5.cur_sel", 32'(c0), 32'd5);

    // Gated, then released with sel 2
    sel = 3'd2; g2a_n = 1'b1;
    step(1);
    chk("gate.y_n", 32'(y0), 32'hFF);
    chk("gate.cur_sel", 32'(c0), 32'd5);
    g2a_n = 1'b0;
    step(1);
    chk("ungate.first", 32'(y0), BLANK ? 32'hFF : 32'hFB);
    step(1);
    chk("ungate.y_n", 32'(y0), 32'hFB);

    // Direct 1 -> 4
    sel = 3'd1;
    step(2);
    chk("dir1.y_n", 32'(y0), 32'hFD);
    sel = 3'd4;
    step(1);
    chk("dir4.first", 32'(y0), BLANK ? 32'hFF : 32'hEF);
    step(1);
    chk("dir4.y_n", 32'(y0), 32'hEF);

    // Scan
    mode = 1'b1;
    step(1);
    chk("idle.y_n", 32'(y0), 32'hFF);
    scan_start = 1'b1;
    step(1);
    scan_start = 1'b0;
    chk("scan0.y_n", 32'(y0), 32'hFE);
    chk("scan0.busy", 32'(b0), 32'd1);
    seq[0] = y2;
    fw0 = 0; nw0 = 0; nw1 = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (i < 6) seq[i] = y2;
      if (w0) begin
        nw0++;
        if (fw0 == 0) fw0 = i;
      end
      if (w1) nw1++;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("u2.seq%0d", i), 32'(seq[i]),
          BLANK ? 32'(seq_bl[i]) : 32'(seq_nb[i]));
    chk("u0.first_wrap", fw0, BLANK ? 39 : 32);
    chk("u0.wrap_count", nw0, 1);
    chk("u1.wrap_count", nw1, BLANK ? 6 : 13);

    // Drop g1 for three cycles
    g1 = 1'b0;
    step(3);
    chk("hold.y_n", 32'(y1), 32'hFF);
    chk("hold.cur_sel", 32'(c1), BLANK ? 32'd2 : 32'd1);
    chk("hold.wrap", 32'(w1), 32'd0);
    chk("hold.busy", 32'(b1), 32'd1);
    g1 = 1'b1;
    step(1);
    chk("resume.cur_sel", 32'(c1), BLANK ? 32'd0 : 32'd2);

    // Start + stop together at cur_sel 3
    for (int i = 0; i < 80 && c0 != 3'd3; i++) step(1);
    chk("wait.cur3", 32'(c0), 32'd3);
    scan_start = 1'b1; scan_stop = 1'b1;
    step(1);
    scan_start = 1'b0; scan_stop = 1'b0;
    chk("stop.y_n", 32'(y0), 32'hFF);
    chk("stop.busy", 32'(b0), 32'd0);
    chk("stop.wrap", 32'(w0), 32'd0);

    // Async reset mid-scan
    scan_start = 1'b1;
    step(1);
    scan_start = 1'b0;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.y_n", 32'(y0), 32'hFF);
    chk("arst.cur_sel", 32'(c0), 32'd0);
    chk("arst.busy", 32'(b0), 32'd0);
    chk("arst.u1.y_n", 32'(y1), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 1'b0;

    // Direct sweep, one gated cycle via g2b_n
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step(2);
    end
    g2b_n = 1'b1;
    step(1);
    chk("g2b.y_n", 32'(y0), 32'hFF);
    g2b_n = 1'b0;
    step(2);
    chk("sweep.y_n", 32'(y0), 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
